// File: rtl/thor2024_icache_fill_pkg.sv
// Shared types and helpers for the I-cache line-fill controller.
package thor2024_icache_fill_pkg;

   typedef logic [31:0] address_t;
   typedef logic [15:0] asid_t;

   localparam int ICacheLineWidth   = 512;
   localparam int ICacheBundleWidth = 128;
   localparam int ICacheBundles     = ICacheLineWidth / ICacheBundleWidth;

   typedef struct packed {
      logic [3:0]                 v;
      logic                       m;
      asid_t                      asid;
      address_t                   vtag;
      address_t                   ptag;
      logic [ICacheLineWidth-1:0] data;
   } ICacheLine;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      DRAIN,
      WRITE,
      ERR
   } fill_state_t;

   // Bundle-aligned address of bundle k within the line containing padr.
   function automatic address_t bundle_adr(input address_t padr, input logic [1:0] k);
      return (padr & ~address_t'(63)) | {26'b0, k, 4'h0};
   endfunction

endpackage

// File: rtl/thor2024_icache_fill.sv
// I-cache miss controller: critical-bundle-first fill of one line with early
// forwarding of the critical bundle and a single cache write at the end.
module thor2024_icache_fill
   import thor2024_icache_fill_pkg::*;
#(
   parameter int AW   = 32,
   parameter int ASW  = 16,
   parameter int NBUN = ICacheBundles
) (
   input  logic                         rst_i,
   input  logic                         clk_i,
   input  logic                         miss_i,
   input  logic [AW-1:0]                miss_vadr_i,
   input  logic [AW-1:0]                miss_padr_i,
   input  logic [ASW-1:0]               miss_asid_i,
   input  logic                         abort_i,
   output logic                         busy_o,
   output logic                         mem_req_o,
   output logic [AW-1:0]                mem_adr_o,
   input  logic                         mem_ack_i,
   input  logic                         mem_vld_i,
   input  logic                         mem_err_i,
   input  logic [ICacheBundleWidth-1:0] mem_dat_i,
   output logic                         byp_vld_o,
   output logic [ICacheBundleWidth-1:0] byp_dat_o,
   output logic                         wr_o,
   output ICacheLine                    line_o,
   output logic                         err_o
);

   localparam int KW = $clog2(NBUN);

   fill_state_t                state_q, state_d;
   logic [AW-1:0]              vadr_q, vadr_d;
   logic [AW-1:0]              padr_q, padr_d;
   logic [ASW-1:0]             asid_q, asid_d;
   logic [KW-1:0]              k_q, k_d;
   logic [KW-1:0]              cnt_q, cnt_d;
   logic [NBUN-1:0]            v_q, v_d;
   logic [ICacheLineWidth-1:0] data_q, data_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         vadr_q  <= '0;
         padr_q  <= '0;
         asid_q  <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
         v_q     <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         vadr_q  <= vadr_d;
         padr_q  <= padr_d;
         asid_q  <= asid_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         v_q     <= v_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      vadr_d    = vadr_q;
      padr_d    = padr_q;
      asid_d    = asid_q;
      k_d       = k_q;
      cnt_d     = cnt_q;
      v_d       = v_q;
      data_d    = data_q;
      busy_o    = (state_q != IDLE);
      mem_req_o = 1'b0;
      mem_adr_o = '0;
      byp_vld_o = 1'b0;
      byp_dat_o = '0;
      wr_o      = 1'b0;
      line_o    = '0;
      err_o     = 1'b0;

      case (state_q)
         IDLE: begin
            if (miss_i && !abort_i) begin
               vadr_d  = miss_vadr_i;
               padr_d  = miss_padr_i;
               asid_d  = miss_asid_i;
               k_d     = miss_padr_i[4 +: KW];
               cnt_d   = '0;
               v_d     = '0;
               state_d = REQ;
            end
         end

         REQ: begin
            mem_req_o = 1'b1;
            mem_adr_o = bundle_adr(padr_q, k_q);
            // An accepted request must still have its response consumed.
            if (abort_i)
               state_d = mem_ack_i ? DRAIN : IDLE;
            else if (mem_ack_i)
               state_d = WAIT;
         end

         WAIT: begin
            if (abort_i) begin
               state_d = mem_vld_i ? IDLE : DRAIN;
            end else if (mem_vld_i) begin
               if (mem_err_i) begin
                  state_d = ERR;
               end else begin
                  data_d[k_q*ICacheBundleWidth +: ICacheBundleWidth] = mem_dat_i;
                  v_d[k_q] = 1'b1;
                  k_d      = k_q + KW'(1);
                  cnt_d    = cnt_q + KW'(1);
                  if (cnt_q == '0) begin
                     byp_vld_o = 1'b1;
                     byp_dat_o = mem_dat_i;
                  end
                  state_d = (cnt_q == KW'(NBUN-1)) ? WRITE : REQ;
               end
            end
         end

         DRAIN: begin
            if (mem_vld_i)
               state_d = IDLE;
         end

         WRITE: begin
            wr_o        = 1'b1;
            line_o.v    = v_q;
            line_o.m    = 1'b0;
            line_o.asid = asid_q;
            line_o.vtag = vadr_q & ~address_t'(63);
            line_o.ptag = padr_q & ~address_t'(63);
            line_o.data = data_q;
            state_d     = IDLE;
         end

         ERR: begin
            err_o   = 1'b1;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_thor2024_icache_fill.sv
// Directed testbench for the I-cache line-fill controller.
module tb_thor2024_icache_fill;
   import thor2024_icache_fill_pkg::*;

   logic         rst_i, clk_i;
   logic         miss_i, abort_i;
   logic [31:0]  miss_vadr_i, miss_padr_i;
   logic [15:0]  miss_asid_i;
   logic         busy_o, mem_req_o;
   logic [31:0]  mem_adr_o;
   logic         mem_ack_i, mem_vld_i, mem_err_i;
   logic [127:0] mem_dat_i;
   logic         byp_vld_o;
   logic [127:0] byp_dat_o;
   logic         wr_o, err_o;
   ICacheLine    line_o;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int wr_cnt = 0;
   int err_cnt = 0;

   thor2024_icache_fill dut (
      .rst_i(rst_i), .clk_i(clk_i),
      .miss_i(miss_i), .miss_vadr_i(miss_vadr_i), .miss_padr_i(miss_padr_i),
      .miss_asid_i(miss_asid_i), .abort_i(abort_i), .busy_o(busy_o),
      .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o), .mem_ack_i(mem_ack_i),
      .mem_vld_i(mem_vld_i), .mem_err_i(mem_err_i), .mem_dat_i(mem_dat_i),
      .byp_vld_o(byp_vld_o), .byp_dat_o(byp_dat_o), .wr_o(wr_o),
      .line_o(line_o), .err_o(err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   always @(negedge clk_i) begin
      if (wr_o) wr_cnt <= wr_cnt + 1;
      if (err_o) err_cnt <= err_cnt + 1;
   end

   typedef struct packed {
      logic [31:0]       vadr;
      logic [31:0]       padr;
      logic [15:0]       asid;
      int                ack_dly;
      int                err_at;
      logic [3:0][31:0]  exp_adr;
      logic [3:0][1:0]   exp_slice;
      logic [31:0]       exp_vtag;
      logic [31:0]       exp_ptag;
      int                exp_wr_cyc;
   } fill_vec_t;

   fill_vec_t vecs[4];

   function automatic fill_vec_t mk(input logic [31:0] vadr, input logic [31:0] padr,
                                    input logic [15:0] asid, input int dly, input int err_at,
                                    input logic [31:0] a0, input logic [31:0] a1,
                                    input logic [31:0] a2, input logic [31:0] a3,
                                    input logic [1:0] s0, input logic [1:0] s1,
                                    input logic [1:0] s2, input logic [1:0] s3,
                                    input logic [31:0] vtag, input logic [31:0] ptag,
                                    input int wrc);
      fill_vec_t r;
      r.vadr = vadr; r.padr = padr; r.asid = asid;
      r.ack_dly = dly; r.err_at = err_at;
      r.exp_adr = {a3, a2, a1, a0};
      r.exp_slice = {s3, s2, s1, s0};
      r.exp_vtag = vtag; r.exp_ptag = ptag;
      r.exp_wr_cyc = wrc;
      return r;
   endfunction

   task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_output({tag, " busy_o"}, 512'(busy_o), 512'(0));
      check_output({tag, " mem_req_o"}, 512'(mem_req_o), 512'(0));
      check_output({tag, " mem_adr_o"}, 512'(mem_adr_o), 512'(0));
      check_output({tag, " byp_vld_o"}, 512'(byp_vld_o), 512'(0));
      check_output({tag, " wr_o"}, 512'(wr_o), 512'(0));
      check_output({tag, " err_o"}, 512'(err_o), 512'(0));
      check_output({tag, " line_o"}, 512'(line_o), 512'(0));
   endtask

   task automatic start_miss(input logic [31:0] vadr, input logic [31:0] padr, input logic [15:0] asid);
      miss_i = 1'b1; miss_vadr_i = vadr; miss_padr_i = padr; miss_asid_i = asid;
      @(negedge clk_i);
      miss_i = 1'b0;
   endtask

   // Runs one complete fill (or error-terminated fill) from the table.
   task automatic apply_stimulus(input fill_vec_t tv, input int sc);
      logic [127:0] dat;
      logic [511:0] exp_data;
      logic         is_err;
      int           c0, wr0, err0;
      exp_data = '0;
      wr0 = wr_cnt;
      err0 = err_cnt;
      start_miss(tv.vadr, tv.padr, tv.asid);
      c0 = cyc;
      check_output($sformatf("v%0d busy", sc), 512'(busy_o), 512'(1));
      for (int i = 0; i < 4; i++) begin
         for (int d = 0; d < tv.ack_dly; d++) begin
            check_output($sformatf("v%0d b%0d req hold", sc, i), 512'(mem_req_o), 512'(1));
            check_output($sformatf("v%0d b%0d adr hold", sc, i), 512'(mem_adr_o), 512'(tv.exp_adr[i]));
            @(negedge clk_i);
         end
         mem_ack_i = 1'b1;
         #1;
         check_output($sformatf("v%0d b%0d req", sc, i), 512'(mem_req_o), 512'(1));
         check_output($sformatf("v%0d b%0d adr", sc, i), 512'(mem_adr_o), 512'(tv.exp_adr[i]));
         @(negedge clk_i);
         mem_ack_i = 1'b0;
         check_output($sformatf("v%0d b%0d req drop", sc, i), 512'(mem_req_o), 512'(0));
         dat = {32'(sc), 32'(i), 32'hC0DE_0000 | 32'(i), tv.padr};
         is_err = (i == tv.err_at);
         mem_vld_i = 1'b1; mem_dat_i = dat; mem_err_i = is_err;
         #1;
         if (i == 0 && !is_err) begin
            check_output($sformatf("v%0d byp_vld", sc), 512'(byp_vld_o), 512'(1));
            check_output($sformatf("v%0d byp_dat", sc), 512'(byp_dat_o), 512'(dat));
            check_output($sformatf("v%0d byp cycle", sc), 512'(cyc - c0 + 1), 512'(2 + tv.ack_dly));
         end else begin
            check_output($sformatf("v%0d b%0d byp_vld", sc, i), 512'(byp_vld_o), 512'(0));
         end
         @(negedge clk_i);
         mem_vld_i = 1'b0; mem_err_i = 1'b0;
         if (is_err) begin
            check_output($sformatf("v%0d err_o", sc), 512'(err_o), 512'(1));
            check_output($sformatf("v%0d err wr_o", sc), 512'(wr_o), 512'(0));
            @(negedge clk_i);
            check_output($sformatf("v%0d err busy", sc), 512'(busy_o), 512'(0));
            check_output($sformatf("v%0d err pulses", sc), 512'(err_cnt - err0), 512'(1));
            check_output($sformatf("v%0d err no write", sc), 512'(wr_cnt - wr0), 512'(0));
            return;
         end
         exp_data[tv.exp_slice[i]*128 +: 128] = dat;
      end
      check_output($sformatf("v%0d wr_o", sc), 512'(wr_o), 512'(1));
      check_output($sformatf("v%0d wr cycle", sc), 512'(cyc - c0 + 1), 512'(tv.exp_wr_cyc));
      check_output($sformatf("v%0d line.v", sc), 512'(line_o.v), 512'(4'hF));
      check_output($sformatf("v%0d line.m", sc), 512'(line_o.m), 512'(0));
      check_output($sformatf("v%0d line.asid", sc), 512'(line_o.asid), 512'(tv.asid));
      check_output($sformatf("v%0d line.vtag", sc), 512'(line_o.vtag), 512'(tv.exp_vtag));
      check_output($sformatf("v%0d line.ptag", sc), 512'(line_o.ptag), 512'(tv.exp_ptag));
      check_output($sformatf("v%0d line.data", sc), line_o.data, exp_data);
      @(negedge clk_i);
      check_output($sformatf("v%0d wr pulse", sc), 512'(wr_cnt - wr0), 512'(1));
      check_output($sformatf("v%0d done busy", sc), 512'(busy_o), 512'(0));
      check_output($sformatf("v%0d done wr_o", sc), 512'(wr_o), 512'(0));
   endtask

   initial begin
      int wr0;
      rst_i = 1'b1; miss_i = 1'b0; abort_i = 1'b0;
      miss_vadr_i = '0; miss_padr_i = '0; miss_asid_i = '0;
      mem_ack_i = 1'b0; mem_vld_i = 1'b0; mem_err_i = 1'b0; mem_dat_i = '0;

      vecs[0] = mk(32'h0040_1000, 32'h0000_1000, 16'h0011, 0, 4,
                   32'h1000, 32'h1010, 32'h1020, 32'h1030, 2'd0, 2'd1, 2'd2, 2'd3,
                   32'h0040_1000, 32'h0000_1000, 9);
      vecs[1] = mk(32'h0080_2034, 32'h0000_1034, 16'h00A5, 0, 4,
                   32'h1030, 32'h1000, 32'h1010, 32'h1020, 2'd3, 2'd0, 2'd1, 2'd2,
                   32'h0080_2000, 32'h0000_1000, 9);
      vecs[2] = mk(32'h1234_567F, 32'hFFFF_FFE8, 16'hFFFF, 3, 4,
                   32'hFFFF_FFE0, 32'hFFFF_FFF0, 32'hFFFF_FFC0, 32'hFFFF_FFD0,
                   2'd2, 2'd3, 2'd0, 2'd1, 32'h1234_5640, 32'hFFFF_FFC0, 21);
      vecs[3] = mk(32'h0000_2010, 32'h0000_2010, 16'h0000, 0, 1,
                   32'h2010, 32'h2020, 32'h2030, 32'h2000, 2'd1, 2'd2, 2'd3, 2'd0,
                   32'h0000_2000, 32'h0000_2000, 0);

      repeat (3) @(negedge clk_i);
      check_idle_outputs("reset");
      rst_i = 1'b0;
      @(negedge clk_i);
      check_idle_outputs("post-reset");

      for (int i = 0; i < 4; i++) apply_stimulus(vecs[i], i);

      // Abort wins over a simultaneous miss in IDLE.
      miss_i = 1'b1; abort_i = 1'b1; miss_padr_i = 32'h4000;
      @(negedge clk_i);
      miss_i = 1'b0; abort_i = 1'b0;
      check_output("abort prio busy", 512'(busy_o), 512'(0));

      // Abort in WAIT after the first bundle; stale response arrives in DRAIN.
      wr0 = wr_cnt;
      start_miss(32'h3000, 32'h3000, 16'h1);
      mem_ack_i = 1'b1; @(negedge clk_i); mem_ack_i = 1'b0;
      mem_vld_i = 1'b1; mem_dat_i = 128'h1111; #1;
      check_output("drain b0 byp_vld", 512'(byp_vld_o), 512'(1));
      @(negedge clk_i); mem_vld_i = 1'b0;
      mem_ack_i = 1'b1; @(negedge clk_i); mem_ack_i = 1'b0;
      abort_i = 1'b1; @(negedge clk_i); abort_i = 1'b0;
      check_output("drain busy1", 512'(busy_o), 512'(1));
      @(negedge clk_i);
      check_output("drain busy2", 512'(busy_o), 512'(1));
      mem_vld_i = 1'b1; mem_dat_i = 128'h2222; #1;
      check_output("drain byp_vld", 512'(byp_vld_o), 512'(0));
      @(negedge clk_i); mem_vld_i = 1'b0;
      check_output("drain idle", 512'(busy_o), 512'(0));
      check_output("drain no write", 512'(wr_cnt - wr0), 512'(0));
      apply_stimulus(vecs[0], 10);

      // Abort in REQ before ack goes straight back to IDLE.
      start_miss(32'h5000, 32'h5000, 16'h2);
      abort_i = 1'b1; @(negedge clk_i); abort_i = 1'b0;
      check_output("req abort busy", 512'(busy_o), 512'(0));
      check_output("req abort req", 512'(mem_req_o), 512'(0));

      // Abort together with ack must drain the outstanding response.
      start_miss(32'h5000, 32'h5000, 16'h2);
      abort_i = 1'b1; mem_ack_i = 1'b1; @(negedge clk_i);
      abort_i = 1'b0; mem_ack_i = 1'b0;
      check_output("ack abort busy", 512'(busy_o), 512'(1));
      mem_vld_i = 1'b1; @(negedge clk_i); mem_vld_i = 1'b0;
      check_output("ack abort idle", 512'(busy_o), 512'(0));

      // Abort coincident with a response in WAIT skips DRAIN.
      start_miss(32'h6000, 32'h6000, 16'h3);
      mem_ack_i = 1'b1; @(negedge clk_i); mem_ack_i = 1'b0;
      abort_i = 1'b1; mem_vld_i = 1'b1; mem_dat_i = 128'h3333; #1;
      check_output("vld abort byp", 512'(byp_vld_o), 512'(0));
      @(negedge clk_i); abort_i = 1'b0; mem_vld_i = 1'b0;
      check_output("vld abort busy", 512'(busy_o), 512'(0));

      // Reset mid-fill, then a stale response.
      wr0 = wr_cnt;
      start_miss(32'h7000, 32'h7000, 16'h4);
      mem_ack_i = 1'b1; @(negedge clk_i); mem_ack_i = 1'b0;
      rst_i = 1'b1; @(negedge clk_i); rst_i = 1'b0;
      check_idle_outputs("midreset");
      mem_vld_i = 1'b1; mem_dat_i = 128'h4444; #1;
      check_output("midreset byp", 512'(byp_vld_o), 512'(0));
      @(negedge clk_i); mem_vld_i = 1'b0;
      check_output("midreset busy", 512'(busy_o), 512'(0));
      @(negedge clk_i);
      check_output("midreset no write", 512'(wr_cnt - wr0), 512'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
